wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 137 +++++++++++++
 tb/tb_wb_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: one MEM->WB pipeline register set plus combinational
// result selection, load extraction and misaligned/illegal load detection.
module wb_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallW,
   input  logic            FlushW,
   input  logic            RegWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ReadDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [2:0]      Funct3M,
   output logic            RegWriteW,
   output logic [4:0]      RdW,
   output logic [XLEN-1:0] ResultW,
   output logic            LoadFaultW
);

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_LINK = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic            reg_write_q;
   logic [1:0]      result_src_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] pc4_q;
   logic [2:0]      funct3_q;

   logic [1:0]      off;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_data;
   logic            load_faulty;
   logic            load_fault;

   // Pipeline register: flush beats stall, stall beats capture; reset and
   // flush both produce the same all-zero bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= SRC_ALU;
         rd_q         <= '0;
         alu_q        <= '0;
         rdata_q      <= '0;
         pc4_q        <= '0;
         funct3_q     <= '0;
      end else if (FlushW) begin
         reg_write_q  <= 1'b0;
         result_src_q <= SRC_ALU;
         rd_q         <= '0;
         alu_q        <= '0;
         rdata_q      <= '0;
         pc4_q        <= '0;
         funct3_q     <= '0;
      end else if (!StallW) begin
         reg_write_q  <= RegWriteM;
         result_src_q <= ResultSrcM;
         rd_q         <= RdM;
         alu_q        <= ALUResultM;
         rdata_q      <= ReadDataM;
         pc4_q        <= PCPlus4M;
         funct3_q     <= Funct3M;
      end
   end

   assign off = alu_q[1:0];

   // Byte and halfword lanes picked by the low address bits; halfwords
   // only ever come from lane 0 or 2, odd offsets are caught as faults.
   always_comb begin
      byte_sel = rdata_q[7:0];
      case (off)
         2'd0: byte_sel = rdata_q[7:0];
         2'd1: byte_sel = rdata_q[15:8];
         2'd2: byte_sel = rdata_q[23:16];
         2'd3: byte_sel = rdata_q[31:24];
         default: byte_sel = rdata_q[7:0];
      endcase
      half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
   end

   // Load extension and fault classification by load type.
   always_comb begin
      load_data   = '0;
      load_faulty = 1'b0;
      case (funct3_q)
         F3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: load_data = {24'd0, byte_sel};
         F3_LH: begin
            load_data   = {{16{half_sel[15]}}, half_sel};
            load_faulty = off[0];
         end
         F3_LHU: begin
            load_data   = {16'd0, half_sel};
            load_faulty = off[0];
         end
         F3_LW: begin
            load_data   = rdata_q;
            load_faulty = (off != 2'b00);
         end
         default: begin
            load_data   = '0;
            load_faulty = 1'b1;
         end
      endcase
   end

   assign load_fault = (result_src_q == SRC_LOAD) && reg_write_q && load_faulty;

   // Writeback data select; a faulting load writes nothing and shows zero.
   always_comb begin
      ResultW = alu_q;
      case (result_src_q)
         SRC_LOAD: ResultW = load_data;
         SRC_LINK: ResultW = pc4_q;
         default:  ResultW = alu_q;
      endcase
      if (load_fault) ResultW = '0;
   end

   assign LoadFaultW = load_fault;
   assign RdW        = rd_q;
   assign RegWriteW  = reg_write_q && (rd_q != 5'd0) && !load_fault;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, stall/flush and async-reset
// sequences, then random traffic against a behavioural model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallW, FlushW, RegWriteM;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
   logic [2:0]  Funct3M;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        LoadFaultW;

   int cmp_count = 0;
   int err_count = 0;

   wb_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
      .Funct3M(Funct3M), .RegWriteW(RegWriteW), .RdW(RdW),
      .ResultW(ResultW), .LoadFaultW(LoadFaultW)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic [2:0]  f3;
   } ins_t;

   typedef struct {
      ins_t        i;
      logic        exp_rw;
      logic [4:0]  exp_rd;
      logic [31:0] exp_res;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        fault;
      logic        res_known;
   } outs_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input ins_t i);
      RegWriteM  = i.rw;
      ResultSrcM = i.src;
      RdM        = i.rd;
      ALUResultM = i.alu;
      ReadDataM  = i.rdata;
      PCPlus4M   = i.pc4;
      Funct3M    = i.f3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input logic rw, input logic [4:0] rd,
                             input logic [31:0] res, input logic fault);
      check({name, ".RegWriteW"},  {31'd0, RegWriteW},  {31'd0, rw});
      check({name, ".RdW"},        {27'd0, RdW},        {27'd0, rd});
      check({name, ".ResultW"},    ResultW,             res);
      check({name, ".LoadFaultW"}, {31'd0, LoadFaultW}, {31'd0, fault});
   endtask

   // Reference model straight from the load/writeback rules.
   function automatic outs_t ref_model(input ins_t i);
      outs_t       o;
      int unsigned off;
      logic [31:0] b, h, ld;
      logic        faulty;
      off = i.alu % 4;
      b = (i.rdata >> (8 * off)) & 32'hFF;
      h = (i.rdata >> (8 * (off & 2))) & 32'hFFFF;
      faulty = 1'b0;
      ld = 32'd0;
      case (i.f3)
         3'd0: ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4: ld = b;
         3'd1: begin ld = (h >= 32768) ? h + 32'hFFFF_0000 : h; faulty = (off % 2) == 1; end
         3'd5: begin ld = h; faulty = (off % 2) == 1; end
         3'd2: begin ld = i.rdata; faulty = (off != 0); end
         default: faulty = 1'b1;
      endcase
      o.fault = (i.src == 2'd1) && i.rw && faulty;
      o.res_known = !((i.src == 2'd1) && faulty && !o.fault);
      if (o.fault)            o.res = 32'd0;
      else if (i.src == 2'd1) o.res = ld;
      else if (i.src == 2'd2) o.res = i.pc4;
      else                    o.res = i.alu;
      o.rd = i.rd;
      o.rw = i.rw && (i.rd != 0) && !o.fault;
      return o;
   endfunction

   vec_t  vecs[13];
   ins_t  st, nx, bubble, tmp;
   outs_t m;
   logic  rs, rf;

   initial begin
      //          rw  src    rd     alu           rdata          pc4           f3      exp_rw exp_rd res         fault
      vecs[0]  = '{'{1, 2'b00, 5'd5,  32'h0000_1234, 32'h0,         32'h0,        3'b010}, 1, 5'd5,  32'h0000_1234, 0};
      vecs[1]  = '{'{1, 2'b01, 5'd3,  32'h0000_0100, 32'h80F0_7F81, 32'h0,        3'b000}, 1, 5'd3,  32'hFFFF_FF81, 0};
      vecs[2]  = '{'{1, 2'b01, 5'd3,  32'h0000_0103, 32'h80F0_7F81, 32'h0,        3'b100}, 1, 5'd3,  32'h0000_0080, 0};
      vecs[3]  = '{'{1, 2'b01, 5'd3,  32'h0000_0102, 32'h80F0_7F81, 32'h0,        3'b001}, 1, 5'd3,  32'hFFFF_80F0, 0};
      vecs[4]  = '{'{1, 2'b01, 5'd3,  32'h0000_0100, 32'h80F0_7F81, 32'h0,        3'b101}, 1, 5'd3,  32'h0000_7F81, 0};
      vecs[5]  = '{'{1, 2'b01, 5'd3,  32'h0000_1002, 32'h80F0_7F81, 32'h0,        3'b010}, 0, 5'd3,  32'h0,         1};
      vecs[6]  = '{'{1, 2'b01, 5'd4,  32'h0000_1000, 32'h80F0_7F81, 32'h0,        3'b011}, 0, 5'd4,  32'h0,         1};
      vecs[7]  = '{'{1, 2'b00, 5'd0,  32'h0000_0055, 32'h0,         32'h0,        3'b000}, 0, 5'd0,  32'h0000_0055, 0};
      vecs[8]  = '{'{1, 2'b10, 5'd1,  32'h0000_0999, 32'h0,         32'h0000_0104, 3'b000}, 1, 5'd1,  32'h0000_0104, 0};
      vecs[9]  = '{'{1, 2'b11, 5'd2,  32'h0000_ABCD, 32'h0,         32'h0000_0500, 3'b000}, 1, 5'd2,  32'h0000_ABCD, 0};
      vecs[10] = '{'{0, 2'b01, 5'd6,  32'h0000_0001, 32'h1122_3344, 32'h0,        3'b100}, 0, 5'd6,  32'h0000_0033, 0};
      vecs[11] = '{'{1, 2'b01, 5'd31, 32'h0000_0001, 32'h0000_8000, 32'h0,        3'b000}, 1, 5'd31, 32'hFFFF_FF80, 0};
      vecs[12] = '{'{1, 2'b01, 5'd8,  32'h0000_0003, 32'h1234_5678, 32'h0,        3'b101}, 0, 5'd8,  32'h0,         1};
      bubble = '{0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000};

      // Reset held with a live instruction on the M side.
      rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      drive('{1, 2'b10, 5'd9, 32'h1111, 32'h2222, 32'h3333, 3'b010});
      tick(); tick();
      check_outs("reset", 0, 5'd0, 32'h0, 0);
      @(negedge clk); rst = 1'b1;

      // Directed vectors, one capture each.
      for (int k = 0; k < 13; k++) begin
         drive(vecs[k].i);
         tick();
         check_outs($sformatf("vec%0d", k), vecs[k].exp_rw, vecs[k].exp_rd,
                    vecs[k].exp_res, vecs[k].exp_fault);
      end

      // Stall holds rd=7 across three edges of changing inputs.
      drive('{1, 2'b00, 5'd7, 32'h0000_0777, 32'h0, 32'h0, 3'b000});
      tick();
      StallW = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive('{1, 2'b01, 5'(12 + k), 32'h0000_0999 + k, 32'hFFFF_FFFF, 32'h40, 3'b000});
         tick();
         check_outs($sformatf("stall%0d", k), 1, 5'd7, 32'h0000_0777, 0);
      end
      FlushW = 1'b1;
      tick();
      check_outs("stall_flush", 0, 5'd0, 32'h0, 0);
      StallW = 1'b0; FlushW = 1'b0;

      // Asynchronous reset between edges drops a live write at once.
      drive('{1, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 3'b000});
      tick();
      check_outs("pre_rst", 1, 5'd5, 32'h0000_1234, 0);
      #2 rst = 1'b0;
      #1 check_outs("async_rst", 0, 5'd0, 32'h0, 0);
      tick();
      tick();
      check_outs("rst_hold", 0, 5'd0, 32'h0, 0);
      @(negedge clk); rst = 1'b1; StallW = 1'b1;
      tick();
      check_outs("post_rst_stall", 0, 5'd0, 32'h0, 0);
      StallW = 1'b0;
      tick();
      check_outs("post_rst_cap", 1, 5'd5, 32'h0000_1234, 0);

      // Random traffic against the model.
      FlushW = 1'b1;
      tick();
      FlushW = 1'b0;
      st = bubble;
      for (int k = 0; k < 400; k++) begin
         nx.rw    = ($urandom_range(0, 3) != 0);
         nx.src   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         nx.rd    = 5'($urandom_range(0, 31));
         nx.alu   = $urandom;
         nx.rdata = $urandom;
         nx.pc4   = $urandom;
         nx.f3    = 3'($urandom_range(0, 7));
         rs = ($urandom_range(0, 3) == 0);
         rf = ($urandom_range(0, 15) == 0);
         drive(nx);
         StallW = rs;
         FlushW = rf;
         tick();
         if (rf)       st = bubble;
         else if (!rs) st = nx;
         tmp = st;
         m = ref_model(tmp);
         check("rnd.RegWriteW",  {31'd0, RegWriteW},  {31'd0, m.rw});
         check("rnd.RdW",        {27'd0, RdW},        {27'd0, m.rd});
         check("rnd.LoadFaultW", {31'd0, LoadFaultW}, {31'd0, m.fault});
         if (m.res_known) check("rnd.ResultW", ResultW, m.res);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
